// File: rtl/pc16_pkg.sv
// Shared types and defaults for the pc16 program counter.
package pc16_pkg;

    localparam int unsigned PC_WIDTH        = 16;
    localparam logic [15:0] PC_RESET_VECTOR = 16'h0000;
    localparam int unsigned HIST_DEPTH      = 4;
    localparam int unsigned HIST_PTR_W      = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

endpackage

// File: rtl/register16.sv
// WIDTH-bit register with load enable and async active-low clear to CLR_VAL.
module register16 #(
    parameter int unsigned      WIDTH   = 16,
    parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= CLR_VAL;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc16.sv
// Hack program counter with fetch stall handshake and jump-to-self halt detection.
// Optional load-history ring buffer enabled by defining PC16_HIST_EN.
module pc16
    import pc16_pkg::*;
#(
    parameter int unsigned      WIDTH        = PC_WIDTH,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
    parameter bit               HALT_DETECT  = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] in,
    input  logic             load,
    input  logic             inc,
    input  logic             reset,
    output logic [WIDTH-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             halted
`ifdef PC16_HIST_EN
   ,input  logic [HIST_PTR_W-1:0] hist_idx,
    output logic [WIDTH-1:0]      hist_data
`endif
);

    state_t           state_q;
    state_t           state_d;
    logic             rel_q;
    logic             out_en;
    logic [WIDTH-1:0] out_d;
    logic             hist_wr;

    register16 #(
        .WIDTH   (WIDTH),
        .CLR_VAL (RESET_VECTOR)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (out_en),
        .d     (out_d),
        .q     (out)
    );

    // rel_q marks the edge that takes reset release; IDLE leaves only after it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            rel_q     <= 1'b0;
            out_valid <= 1'b0;
            halted    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rel_q     <= 1'b1;
            out_valid <= (state_d == RUN);
            halted    <= (state_d == HALT);
        end
    end

    always_comb begin
        state_d = state_q;
        out_en  = 1'b0;
        out_d   = out;
        hist_wr = 1'b0;
        case (state_q)
            IDLE: begin
                if (rel_q) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                // out_valid is 1 throughout RUN, so out_ready alone qualifies acceptance.
                if (out_ready) begin
                    if (reset) begin
                        out_en = 1'b1;
                        out_d  = RESET_VECTOR;
                    end else if (load) begin
                        if (HALT_DETECT && (in == out)) begin
                            state_d = HALT;
                        end else begin
                            out_en  = 1'b1;
                            out_d   = in;
                            hist_wr = 1'b1;
                        end
                    end else if (inc) begin
                        out_en = 1'b1;
                        out_d  = out + WIDTH'(1);
                    end
                end
            end
            HALT: begin
                if (reset) begin
                    state_d = RUN;
                    out_en  = 1'b1;
                    out_d   = RESET_VECTOR;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

`ifdef PC16_HIST_EN
    logic [WIDTH-1:0]      hist_q [HIST_DEPTH];
    logic [HIST_PTR_W-1:0] wr_ptr;
    logic [HIST_PTR_W-1:0] rd_ptr;

    // Ring of pre-load addresses; wr_ptr points at the slot to be overwritten next.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < HIST_DEPTH; i++) begin
                hist_q[i] <= RESET_VECTOR;
            end
            wr_ptr <= '0;
        end else if (hist_wr) begin
            hist_q[wr_ptr] <= out;
            wr_ptr         <= wr_ptr + HIST_PTR_W'(1);
        end
    end

    assign rd_ptr    = wr_ptr - HIST_PTR_W'(1) - hist_idx;
    assign hist_data = hist_q[rd_ptr];
`else
    logic unused_hist_wr;
    assign unused_hist_wr = hist_wr;
`endif

endmodule

// File: tb/tb_pc16.sv
// Randomized scoreboard bench for pc16 against an abstract PC model.
module tb_pc16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] in;
    logic        load;
    logic        inc;
    logic        reset;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready;
    logic        halted;
`ifdef PC16_HIST_EN
    logic [1:0]  hist_idx;
    logic [15:0] hist_data;
`endif

    always #5 clk = ~clk;

    pc16 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in),
        .load      (load),
        .inc       (inc),
        .reset     (reset),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .halted    (halted)
`ifdef PC16_HIST_EN
       ,.hist_idx  (hist_idx),
        .hist_data (hist_data)
`endif
    );

    typedef struct packed {
        logic [15:0] pc;
        logic        v;
        logic        h;
    } exp_t;

    exp_t sbq[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    // Reference model: mode 0 = idle, 1 = run, 2 = halt.
    int          m_mode;
    bit          m_armed;
    int unsigned m_pc;
    int unsigned m_hist[4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode  = 0;
        m_armed = 1'b0;
        m_pc    = 0;
        for (int i = 0; i < 4; i++) m_hist[i] = 0;
    endfunction

    function automatic void model_step(input bit ld, input bit ic, input bit rs,
                                       input bit rdy, input logic [15:0] din);
        if (m_mode == 0) begin
            if (m_armed) m_mode = 1;
            m_armed = 1'b1;
        end else if (m_mode == 1) begin
            if (rdy) begin
                if (rs) begin
                    m_pc = 0;
                end else if (ld) begin
                    if (int'(din) == m_pc) begin
                        m_mode = 2;
                    end else begin
                        for (int i = 3; i > 0; i--) m_hist[i] = m_hist[i-1];
                        m_hist[0] = m_pc;
                        m_pc      = din;
                    end
                end else if (ic) begin
                    m_pc = (m_pc + 1) % 65536;
                end
            end
        end else if (rs) begin
            m_pc   = 0;
            m_mode = 1;
        end
    endfunction

`ifdef PC16_HIST_EN
    task automatic hist_chk();
        for (int i = 0; i < 4; i++) begin
            hist_idx = 2'(i);
            #1;
            chk($sformatf("hist[%0d]", i), 32'(hist_data), m_hist[i]);
        end
    endtask
`endif

    // One clock of stimulus: drive at negedge, advance model, queue the post-edge expectation.
    task automatic cyc(input bit ld, input bit ic, input bit rs, input bit rdy,
                       input logic [15:0] din);
        @(negedge clk);
`ifdef PC16_HIST_EN
        hist_chk();
`endif
        load      = ld;
        inc       = ic;
        reset     = rs;
        out_ready = rdy;
        in        = din;
        model_step(ld, ic, rs, rdy, din);
        sbq.push_back('{pc: 16'(m_pc), v: (m_mode == 1), h: (m_mode == 2)});
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_halted", 32'(halted), 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_hold_out", 32'(out), 32'h0);
        chk("rst_hold_valid", 32'(out_valid), 32'h0);
`ifdef PC16_HIST_EN
        hist_chk();
`endif
        @(posedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() != 0) begin
            e = sbq.pop_front();
            chk("out", 32'(out), 32'(e.pc));
            chk("out_valid", 32'(out_valid), 32'(e.v));
            chk("halted", 32'(halted), 32'(e.h));
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          ld, ic, rs, rdy;
        logic [15:0] din;
        rst_n     = 1'b0;
        in        = '0;
        load      = 1'b0;
        inc       = 1'b0;
        reset     = 1'b0;
        out_ready = 1'b0;
`ifdef PC16_HIST_EN
        hist_idx  = '0;
`endif
        model_reset();
        do_reset();

        // Idle edge, then RUN; controls ignored while idle.
        cyc(1, 1, 0, 1, 16'h7777);
        cyc(0, 0, 0, 1, 16'h0000);
        repeat (3) cyc(0, 1, 0, 1, 16'h0000);
        cyc(1, 0, 0, 1, 16'hFFFF);
        cyc(0, 1, 0, 1, 16'h0000);

        // Priority: load over inc, reset over everything.
        cyc(1, 0, 0, 1, 16'h0010);
        cyc(1, 1, 0, 1, 16'h1234);
        cyc(1, 1, 1, 1, 16'h1234);

        // Stall holds inc and a synchronous reset.
        cyc(1, 0, 0, 1, 16'h0005);
        repeat (4) cyc(0, 1, 0, 0, 16'h0000);
        cyc(0, 0, 1, 0, 16'h0000);
        cyc(0, 1, 0, 1, 16'h0000);

        // Jump-to-self halt, frozen under toggling controls, released by reset.
        cyc(1, 0, 0, 1, 16'h0020);
        cyc(1, 0, 0, 1, 16'h0020);
        for (int i = 0; i < 4; i++) cyc(bit'(i % 2), bit'((i + 1) % 2), 0, bit'(i % 2), 16'h0040);
        cyc(1, 1, 1, 0, 16'h0040);
        cyc(0, 1, 0, 1, 16'h0000);

        // History: five loads from out values A..E.
        cyc(1, 0, 0, 1, 16'h0A0A);
        cyc(1, 0, 0, 1, 16'h0B0B);
        cyc(1, 0, 0, 1, 16'h0C0C);
        cyc(1, 0, 0, 1, 16'h0D0D);
        cyc(1, 0, 0, 1, 16'h0E0E);
        cyc(1, 0, 0, 1, 16'h0F0F);
        cyc(0, 0, 0, 1, 16'h0000);

        // Async reset mid-stall.
        repeat (2) cyc(0, 1, 0, 0, 16'h0000);
        do_reset();
        repeat (3) cyc(0, 1, 0, 1, 16'h0000);

        for (int n = 0; n < 600; n++) begin
            ld  = ($urandom % 3) == 0;
            ic  = ($urandom % 2) == 0;
            rs  = ($urandom % 12) == 0;
            rdy = ($urandom % 4) != 0;
            din = (($urandom % 4) == 0) ? 16'(m_pc) : 16'($urandom);
            cyc(ld, ic, rs, rdy, din);
            if (n == 300) do_reset();
        end

        // Async reset mid-halt.
        cyc(1, 0, 0, 1, 16'(m_pc));
        cyc(0, 1, 0, 1, 16'h0000);
        do_reset();
        repeat (3) cyc(0, 1, 0, 1, 16'h0000);

        repeat (3) @(negedge clk);
        chk("sb_drain", 32'(sbq.size()), 32'h0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/pc16.md
Name: pc16

Overview:
- 16-bit Hack program counter that produces the instruction address consumed by the fetch path.
- Sits next to the project01 16-bit gate blocks (the not/and/mux-16 family) as the first sequential datapath stage.
- Priority control: clear > load > increment > hold.
- Adds a fetch-side valid/ready stall handshake and a halt detector for the Hack "jump-to-self" idiom.

Parameters:
- WIDTH, 16, address width; only 16 is verified.
- RESET_VECTOR, 16'h0000, value of out after async reset and after a synchronous clear.
- HALT_DETECT, 1, 1 = enable jump-to-self halt detection; 0 = never enter HALT.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in  input  WIDTH  load value (jump target).
- load  input  1  load in on the next accepted cycle.
- inc  input  1  add 1 on the next accepted cycle.
- reset  input  1  synchronous clear to RESET_VECTOR (Hack PC semantics).
- out  output  WIDTH  current instruction address.
- out_valid  output  1  out is a valid fetch address.
- out_ready  input  1  fetch stage accepts out this cycle.
- halted  output  1  HALT state indicator.

Behaviour:
- Reset is asynchronous and active-low.
  - While rst_n = 0: out = RESET_VECTOR, out_valid = 0, halted = 0, state = IDLE.
  - Deassertion is taken synchronously on the first rising clk edge with rst_n = 1.
- States: IDLE, RUN, HALT.
- IDLE
  - Entered from reset; out_valid = 0.
  - Unconditionally moves to RUN next cycle.
  - out is held at RESET_VECTOR; control inputs are ignored.
- RUN
  - out_valid = 1.
  - An update is accepted only in a cycle where out_valid & out_ready = 1. With out_ready = 0, out, state and the control inputs' effect are all held (stall); control inputs must be re-presented.
  - On an accepted cycle, next out is chosen in priority order:
    - reset: RESET_VECTOR
    - else load: in
    - else inc: out + 1, modulo 2^WIDTH (16'hFFFF + 1 = 16'h0000; no flag)
    - else: out unchanged
  - Halt detection (HALT_DETECT = 1): an accepted cycle with load = 1, reset = 0 and in == out moves to HALT; out is unchanged.
- HALT
  - halted = 1, out_valid = 0; out is frozen and out_ready is ignored.
  - reset = 1 (synchronous) returns to RUN with out = RESET_VECTOR on the next edge; load and inc are ignored.
  - rst_n = 0 returns to IDLE asynchronously.
- Latency: one cycle from accepted control to new out.
- out is purely registered; no combinational path from any input to out.
- Simultaneous events:
  - reset + load + inc: reset wins.
  - load + inc: load wins.
  - Synchronous reset during a stall (out_ready = 0) is also held; it is not forced through.
- rst_n assertion mid-stall or mid-HALT: immediate return to reset values, no pending update survives.

Optional Feature:
- Macro PC16_HIST_EN.
- Defined:
  - A 4-entry ring buffer records the pre-load value of out on every accepted load that is not a halt.
  - Write pointer wraps 3 -> 0; oldest entry is overwritten.
  - Extra ports: hist_idx input 2 (0 = newest) and hist_data output WIDTH, a combinational read.
  - rst_n clears all entries to RESET_VECTOR and the pointer to 0.
  - Synchronous reset does not clear the buffer.
- Undefined: these ports and this logic are absent; all other behaviour is identical.

Decomposition:
- Package pc16_pkg holds:
  - the state enum type (IDLE, RUN, HALT)
  - the WIDTH default
  - the RESET_VECTOR default
  - the history depth constant (4)
- One sub-module, register16: WIDTH-bit register with load enable, async active-low clear and a clear value.
  - pc16 instantiates it for out; the next-value mux and FSM live in pc16.

Test Plan:
- rst_n pulse low -> out = 16'h0000, out_valid = 0 while low; first edge after release: IDLE, next edge: RUN, out_valid = 1.
- RUN, out_ready = 1, inc = 1 for 3 cycles from 16'h0000 -> out = 1, 2, 3 on successive edges. Preload 16'hFFFF then inc -> 16'h0000.
- Priority: out = 16'h0010, in = 16'h1234:
  - load = 1 & inc = 1 -> out = 16'h1234
  - then reset + load + inc -> out = 16'h0000
- Stall: out = 16'h0005, out_ready = 0, inc = 1 for 4 cycles -> out stays 16'h0005; out_ready = 1 one cycle -> out = 16'h0006.
- Halt: out = 16'h0020, load = 1, in = 16'h0020 -> halted = 1, out_valid = 0, out = 16'h0020 held with inc/load toggling. reset = 1 -> out = 16'h0000, RUN.
- PC16_HIST_EN: five loads from out values A..E -> hist_idx 0..3 read E, D, C, B (A overwritten). rst_n pulse -> all reads 16'h0000.
